// File: rtl/field_serializer.sv
// field_serializer
//
// Purpose:
//   Accepts a packed word of FIELDS fields, each FIELD_W bits, over a
//   valid/ready handshake and emits the fields one per cycle on a narrow
//   valid/ready output. Each beat carries its natural field index and a
//   last flag. The word is captured into a holding register, so outputs
//   never depend combinationally on in_valid/in_data. The last beat of a
//   word can overlap acceptance of the next word, which gives full
//   throughput on back-to-back words.
//
// Parameters:
//   FIELD_W   - width of one field in bits (>= 1)
//   FIELDS    - number of fields per input word (>= 1)
//   MSB_FIRST - 0: field 0 is emitted first; 1: field FIELDS-1 is emitted first
//   IDX_W     - derived index width, $clog2(FIELDS) with a minimum of 1
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   in_valid  in   in_data holds a word
//   in_ready  out  block accepts a word this cycle
//   in_data   in   packed word, field i = in_data[i*FIELD_W +: FIELD_W]
//   out_valid out  out_data holds a field
//   out_ready in   consumer takes the field this cycle
//   out_data  out  current field
//   out_index out  natural index of the current field
//   out_last  out  current beat is the final field of the word

module field_serializer #(
  parameter  int FIELD_W   = 2,
  parameter  int FIELDS    = 2,
  parameter  int MSB_FIRST = 0,
  localparam int IDX_W     = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FIELDS*FIELD_W-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FIELD_W-1:0]          out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FIELDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [FIELDS*FIELD_W-1:0]   hold_q,  hold_d;
  logic [IDX_W-1:0]            cnt_q,   cnt_d;

  logic                        busy;
  logic                        last_beat;
  logic                        in_hs;
  logic [IDX_W-1:0]            index;

  assign busy      = (state_q == EMIT);
  assign last_beat = busy && (cnt_q == LAST_CNT);

  // cnt always counts emission order; index translates it to the natural
  // field number so downstream logic never has to know the emit order.
  always_comb begin
    index = cnt_q;
    if (MSB_FIRST != 0) begin
      index = LAST_CNT - cnt_q;
    end
  end

  // Outputs are driven purely from registered state (plus out_ready for
  // in_ready), never from in_data.
  assign out_valid = busy;
  assign out_last  = last_beat;
  assign out_index = index;
  assign out_data  = hold_q[index*FIELD_W +: FIELD_W];

  // A new word can be taken when idle, or when the final beat of the
  // current word leaves this cycle; the latter removes the bubble between
  // back-to-back words.
  assign in_ready = !reset && (!busy || (out_ready && last_beat));
  assign in_hs    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (out_ready) begin
          if (!last_beat) begin
            cnt_d = cnt_q + IDX_W'(1);
          end else if (in_hs) begin
            hold_d = in_data;
            cnt_d  = '0;
          end else begin
            // cnt stays at the final value; it is reloaded on the next accept.
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
module tb_field_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic reset;
  logic rst_r;

  // Instance A: defaults (FIELD_W=2, FIELDS=2, LSB first)
  logic       a_iv, a_ir, a_ov, a_or, a_last;
  logic [3:0] a_d;
  logic [1:0] a_od;
  logic [0:0] a_idx;

  // Instance M: MSB first
  logic       m_iv, m_ir, m_ov, m_or, m_last;
  logic [3:0] m_d;
  logic [1:0] m_od;
  logic [0:0] m_idx;

  // Instance W: four fields of two bits
  logic       w_iv, w_ir, w_ov, w_or, w_last;
  logic [7:0] w_d;
  logic [1:0] w_od;
  logic [1:0] w_idx;

  // Instance R: randomized, FIELD_W=3, FIELDS=3, MSB first
  localparam int RW = 3;
  localparam int RF = 3;
  logic          r_iv, r_ir, r_ov, r_or, r_last;
  logic [RW*RF-1:0] r_d;
  logic [RW-1:0] r_od;
  logic [1:0]    r_idx;

  field_serializer u_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_index(a_idx), .out_last(a_last)
  );

  field_serializer #(.FIELD_W(2), .FIELDS(2), .MSB_FIRST(1)) u_m (
    .clk(clk), .reset(reset), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_d),
    .out_valid(m_ov), .out_ready(m_or), .out_data(m_od), .out_index(m_idx), .out_last(m_last)
  );

  field_serializer #(.FIELD_W(2), .FIELDS(4), .MSB_FIRST(0)) u_w (
    .clk(clk), .reset(reset), .in_valid(w_iv), .in_ready(w_ir), .in_data(w_d),
    .out_valid(w_ov), .out_ready(w_or), .out_data(w_od), .out_index(w_idx), .out_last(w_last)
  );

  field_serializer #(.FIELD_W(RW), .FIELDS(RF), .MSB_FIRST(1)) u_r (
    .clk(clk), .reset(rst_r), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_d),
    .out_valid(r_ov), .out_ready(r_or), .out_data(r_od), .out_index(r_idx), .out_last(r_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge; inputs are driven
  // there and outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       ov;
    logic [1:0] od;
    logic       idx;
    logic       last;
    logic       ir;
  } vec_t;

  vec_t vecs [16];

  typedef struct packed {
    logic [RW-1:0] d;
    logic [1:0]    idx;
    logic          last;
  } beat_t;

  beat_t q[$];

  initial begin
    // Per-cycle vectors for instance A: inputs in this cycle, then the
    // outputs expected in the same cycle (before the next edge).
    //                iv   d        ordy  ov    od     idx   last  ir
    // single word 1101
    vecs[0]  = '{1'b1, 4'b1101, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
    // backpressure: out_ready low for 3 cycles on beat 1
    vecs[4]  = '{1'b1, 4'b1101, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0111, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1};
    // back-to-back 0110 then 1001
    vecs[10] = '{1'b1, 4'b0110, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'b1001, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'b1001, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; rst_r = 1'b1;
    a_iv = 0; a_d = '0; a_or = 1'b1;
    m_iv = 0; m_d = '0; m_or = 1'b1;
    w_iv = 0; w_d = '0; w_or = 1'b1;
    r_iv = 0; r_d = '0; r_or = 1'b1;

    tick();
    tick();
    #2;
    // in reset: nothing accepted
    check("rst a in_ready", a_ir, 0);
    check("rst w in_ready", w_ir, 0);
    check("rst a out_valid", a_ov, 0);
    check("rst a out_data", a_od, 0);
    check("rst a out_index", a_idx, 0);
    check("rst a out_last", a_last, 0);
    check("rst m out_index", m_idx, 1);
    check("rst w out_index", w_idx, 0);
    tick();
    reset = 1'b0;
    #2;
    check("post-rst a in_ready", a_ir, 1);
    check("post-rst m in_ready", m_ir, 1);
    check("post-rst w out_valid", w_ov, 0);
    tick();

    // Table-driven vectors on instance A
    for (int i = 0; i < 16; i++) begin
      a_iv = vecs[i].iv; a_d = vecs[i].d; a_or = vecs[i].ordy;
      #2;
      check($sformatf("vec%0d out_valid", i), a_ov, vecs[i].ov);
      check($sformatf("vec%0d out_data", i), a_od, vecs[i].od);
      check($sformatf("vec%0d out_index", i), a_idx, vecs[i].idx);
      check($sformatf("vec%0d out_last", i), a_last, vecs[i].last);
      check($sformatf("vec%0d in_ready", i), a_ir, vecs[i].ir);
      tick();
    end

    // MSB-first word 1101: 11 (index 1), then 01 (index 0, last)
    m_iv = 1'b1; m_d = 4'b1101; m_or = 1'b1;
    #2;
    check("msb accept in_ready", m_ir, 1);
    tick();
    m_iv = 1'b0; m_d = 4'b0000;
    #2;
    check("msb b1 out_valid", m_ov, 1);
    check("msb b1 out_data", m_od, 2'b11);
    check("msb b1 out_index", m_idx, 1);
    check("msb b1 out_last", m_last, 0);
    check("msb b1 in_ready", m_ir, 0);
    tick();
    #2;
    check("msb b2 out_data", m_od, 2'b01);
    check("msb b2 out_index", m_idx, 0);
    check("msb b2 out_last", m_last, 1);
    check("msb b2 in_ready", m_ir, 1);
    tick();
    #2;
    check("msb done out_valid", m_ov, 0);

    // Four fields, word E4: beats 00,01,10,11 with indices 0..3
    w_iv = 1'b1; w_d = 8'hE4; w_or = 1'b1;
    tick();
    w_iv = 1'b0; w_d = 8'h00;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("w4 b%0d out_valid", k), w_ov, 1);
      check($sformatf("w4 b%0d out_data", k), w_od, k);
      check($sformatf("w4 b%0d out_index", k), w_idx, k);
      check($sformatf("w4 b%0d out_last", k), w_last, (k == 3) ? 1 : 0);
      check($sformatf("w4 b%0d in_ready", k), w_ir, (k == 3) ? 1 : 0);
      tick();
    end
    #2;
    check("w4 done out_valid", w_ov, 0);
    tick();

    // Reset after beat 1 of 1101 on instance A
    a_iv = 1'b1; a_d = 4'b1101; a_or = 1'b1;
    tick();
    a_iv = 1'b0; a_d = 4'b0000;
    #2;
    check("rstmid b1 out_data", a_od, 2'b01);
    tick();
    reset = 1'b1;
    #2;
    check("rstmid in_ready during reset", a_ir, 0);
    tick();
    reset = 1'b0;
    #2;
    check("rstmid out_valid", a_ov, 0);
    check("rstmid out_data", a_od, 0);
    check("rstmid out_index", a_idx, 0);
    check("rstmid out_last", a_last, 0);
    check("rstmid in_ready", a_ir, 1);
    a_iv = 1'b1; a_d = 4'b0011;
    tick();
    a_iv = 1'b0; a_d = 4'b0000;
    #2;
    check("rstmid new b1 out_valid", a_ov, 1);
    check("rstmid new b1 out_data", a_od, 2'b11);
    check("rstmid new b1 out_index", a_idx, 0);
    check("rstmid new b1 out_last", a_last, 0);
    tick();
    #2;
    check("rstmid new b2 out_data", a_od, 2'b00);
    check("rstmid new b2 out_index", a_idx, 1);
    check("rstmid new b2 out_last", a_last, 1);
    tick();
    #2;
    check("rstmid new done out_valid", a_ov, 0);

    // Randomized run on instance R against a queue of pending beats
    rst_r = 1'b0;
    q.delete();
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic exp_ir;
      r_iv  = ($urandom_range(0, 3) != 0);
      r_d   = RW*RF'($urandom);
      r_or  = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 199) == 0);
      #2;
      exp_ir = !rst_r && ((q.size() == 0) || (r_or && q.size() == 1));
      check($sformatf("rnd%0d in_ready", c), r_ir, exp_ir);
      check($sformatf("rnd%0d out_valid", c), r_ov, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) begin
        check($sformatf("rnd%0d out_data", c), r_od, q[0].d);
        check($sformatf("rnd%0d out_index", c), r_idx, q[0].idx);
        check($sformatf("rnd%0d out_last", c), r_last, q[0].last);
      end
      if (rst_r) begin
        q.delete();
      end else begin
        if (q.size() != 0 && r_or) void'(q.pop_front());
        if (r_iv && exp_ir) begin
          for (int k = 0; k < RF; k++) begin
            beat_t b;
            int fi;
            fi     = RF - 1 - k;
            b.d    = r_d[fi*RW +: RW];
            b.idx  = 2'(fi);
            b.last = (k == RF - 1);
            q.push_back(b);
          end
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
